forward_ysyx23060136: RTL and testbench

FORWARD_YSYX23060136 -- requirements
Module: forward_ysyx23060136

---
 rtl/DEFINES_ysyx23060136.sv | 20 ++
 rtl/FORWARD_MATCH_ysyx23060136.sv | 52 +++++
 rtl/forward_ysyx23060136.sv | 146 ++++++++++++++
 tb/tb_forward_ysyx23060136.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/DEFINES_ysyx23060136.sv
// Shared widths and the forwarding tracking-entry layout.
package defines_ysyx23060136_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned GPR_AW = 5;
    localparam int unsigned CSR_AW = 12;

    // One in-flight producer: GPR and CSR write info of a single instruction.
    typedef struct packed {
        logic              valid;
        logic [GPR_AW-1:0] rd;
        logic              rd_wen;
        logic [XLEN-1:0]   data;
        logic              is_load;
        logic [CSR_AW-1:0] csr_waddr;
        logic              csr_wen;
        logic [XLEN-1:0]   csr_wdata;
    } fwd_entry_t;

endpackage

// File: rtl/FORWARD_MATCH_ysyx23060136.sv
// Per-operand match against the M and W producers; M (youngest) wins.
module FORWARD_MATCH_ysyx23060136
    import defines_ysyx23060136_pkg::*;
(
    input  logic              m_valid,
    input  logic              m_wen,
    input  logic [CSR_AW-1:0] m_addr,
    input  logic [XLEN-1:0]   m_data,
    input  logic              m_is_load,
    input  logic              w_valid,
    input  logic              w_wen,
    input  logic [CSR_AW-1:0] w_addr,
    input  logic [XLEN-1:0]   w_data,
    input  logic [CSR_AW-1:0] src_addr,
    input  logic              skip_zero,
    input  logic [XLEN-1:0]   load_data,
    input  logic              load_valid,
    output logic              hazard_c,
    output logic [XLEN-1:0]   data_c,
    output logic              stall_c
);

    logic src_ok;
    logic m_hit;
    logic w_hit;

    // GPR operands treat index 0 as hard-wired zero; CSRs have no such alias.
    assign src_ok = !skip_zero || (src_addr != '0);
    assign m_hit  = m_valid && m_wen && src_ok && (m_addr == src_addr);
    assign w_hit  = w_valid && w_wen && src_ok && (w_addr == src_addr);

    always_comb begin
        hazard_c = 1'b0;
        data_c   = '0;
        stall_c  = 1'b0;
        if (m_hit) begin
            if (!m_is_load) begin
                hazard_c = 1'b1;
                data_c   = m_data;
            end else if (load_valid) begin
                hazard_c = 1'b1;
                data_c   = load_data;
            end else begin
                stall_c = 1'b1;
            end
        end else if (w_hit) begin
            hazard_c = 1'b1;
            data_c   = w_data;
        end
    end

endmodule

// File: rtl/forward_ysyx23060136.sv
// Operand forwarding for EXU: tracks MEM/WB producers and selects bypass data.
module forward_ysyx23060136
    import defines_ysyx23060136_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              EXU_fire,
    input  logic [GPR_AW-1:0] EXU_rd,
    input  logic              EXU_rd_wen,
    input  logic [XLEN-1:0]   EXU_result,
    input  logic              EXU_is_load,
    input  logic [CSR_AW-1:0] EXU_csr_waddr,
    input  logic              EXU_csr_wen,
    input  logic [XLEN-1:0]   EXU_csr_wdata,
    input  logic              MEM_fire,
    input  logic              WB_fire,
    input  logic [XLEN-1:0]   MEM_load_data,
    input  logic              MEM_load_valid,
    input  logic [GPR_AW-1:0] EXU_rs1,
    input  logic [GPR_AW-1:0] EXU_rs2,
    input  logic [CSR_AW-1:0] EXU_csr_rs_addr,
    output logic [XLEN-1:0]   FORWARD_rs1_data_EXU,
    output logic [XLEN-1:0]   FORWARD_rs2_data_EXU,
    output logic [XLEN-1:0]   FORWARD_csr_rs_data_EXU,
    output logic              FORWARD_rs1_hazard_EXU,
    output logic              FORWARD_rs2_hazard_EXU,
    output logic              FORWARD_csr_rs_hazard_EXU,
    output logic              FORWARD_stall_EXU
);

    fwd_entry_t m_q;
    fwd_entry_t w_q;
    fwd_entry_t exu_entry;
    fwd_entry_t m_to_w;
    logic       rs1_stall;
    logic       rs2_stall;
    logic       csr_stall;
    logic       unused_w_is_load;

    assign unused_w_is_load = w_q.is_load;

    always_comb begin
        exu_entry           = '0;
        exu_entry.valid     = 1'b1;
        exu_entry.rd        = EXU_rd;
        exu_entry.rd_wen    = EXU_rd_wen;
        exu_entry.data      = EXU_result;
        exu_entry.is_load   = EXU_is_load;
        exu_entry.csr_waddr = EXU_csr_waddr;
        exu_entry.csr_wen   = EXU_csr_wen;
        exu_entry.csr_wdata = EXU_csr_wdata;
    end

    // A load resolves to its returned data as it moves into WB.
    always_comb begin
        m_to_w = m_q;
        if (m_q.is_load) begin
            m_to_w.data = MEM_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q <= '0;
            w_q <= '0;
        end else begin
            if (EXU_fire) begin
                m_q <= exu_entry;
            end else if (MEM_fire) begin
                m_q.valid <= 1'b0;
            end
            if (MEM_fire) begin
                w_q <= m_to_w;
            end else if (WB_fire) begin
                w_q.valid <= 1'b0;
            end
        end
    end

    FORWARD_MATCH_ysyx23060136 u_match_rs1 (
        .m_valid    (m_q.valid),
        .m_wen      (m_q.rd_wen),
        .m_addr     (CSR_AW'(m_q.rd)),
        .m_data     (m_q.data),
        .m_is_load  (m_q.is_load),
        .w_valid    (w_q.valid),
        .w_wen      (w_q.rd_wen),
        .w_addr     (CSR_AW'(w_q.rd)),
        .w_data     (w_q.data),
        .src_addr   (CSR_AW'(EXU_rs1)),
        .skip_zero  (1'b1),
        .load_data  (MEM_load_data),
        .load_valid (MEM_load_valid),
        .hazard_c   (FORWARD_rs1_hazard_EXU),
        .data_c     (FORWARD_rs1_data_EXU),
        .stall_c    (rs1_stall)
    );

    FORWARD_MATCH_ysyx23060136 u_match_rs2 (
        .m_valid    (m_q.valid),
        .m_wen      (m_q.rd_wen),
        .m_addr     (CSR_AW'(m_q.rd)),
        .m_data     (m_q.data),
        .m_is_load  (m_q.is_load),
        .w_valid    (w_q.valid),
        .w_wen      (w_q.rd_wen),
        .w_addr     (CSR_AW'(w_q.rd)),
        .w_data     (w_q.data),
        .src_addr   (CSR_AW'(EXU_rs2)),
        .skip_zero  (1'b1),
        .load_data  (MEM_load_data),
        .load_valid (MEM_load_valid),
        .hazard_c   (FORWARD_rs2_hazard_EXU),
        .data_c     (FORWARD_rs2_data_EXU),
        .stall_c    (rs2_stall)
    );

    // CSR write data is known at EXU, so a load never delays a CSR bypass.
    FORWARD_MATCH_ysyx23060136 u_match_csr (
        .m_valid    (m_q.valid),
        .m_wen      (m_q.csr_wen),
        .m_addr     (m_q.csr_waddr),
        .m_data     (m_q.csr_wdata),
        .m_is_load  (1'b0),
        .w_valid    (w_q.valid),
        .w_wen      (w_q.csr_wen),
        .w_addr     (w_q.csr_waddr),
        .w_data     (w_q.csr_wdata),
        .src_addr   (EXU_csr_rs_addr),
        .skip_zero  (1'b0),
        .load_data  (MEM_load_data),
        .load_valid (MEM_load_valid),
        .hazard_c   (FORWARD_csr_rs_hazard_EXU),
        .data_c     (FORWARD_csr_rs_data_EXU),
        .stall_c    (csr_stall)
    );

    assign FORWARD_stall_EXU = rs1_stall || rs2_stall || csr_stall;

    // Retiring a load from MEM before its data has returned is illegal upstream.
    a_load_retire_needs_data : assert property (
        @(posedge clk) disable iff (rst)
        !(MEM_fire && m_q.valid && m_q.is_load && !MEM_load_valid)
    );

endmodule

// File: tb/tb_forward_ysyx23060136.sv
// Directed-vector bench for forward_ysyx23060136 with hand-computed expectations.
module tb_forward_ysyx23060136;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXU_fire;
    logic [4:0]  EXU_rd;
    logic        EXU_rd_wen;
    logic [31:0] EXU_result;
    logic        EXU_is_load;
    logic [11:0] EXU_csr_waddr;
    logic        EXU_csr_wen;
    logic [31:0] EXU_csr_wdata;
    logic        MEM_fire;
    logic        WB_fire;
    logic [31:0] MEM_load_data;
    logic        MEM_load_valid;
    logic [4:0]  EXU_rs1;
    logic [4:0]  EXU_rs2;
    logic [11:0] EXU_csr_rs_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] csr_data;
    logic        rs1_hz;
    logic        rs2_hz;
    logic        csr_hz;
    logic        stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    forward_ysyx23060136 dut (
        .clk                       (clk),
        .rst                       (rst),
        .EXU_fire                  (EXU_fire),
        .EXU_rd                    (EXU_rd),
        .EXU_rd_wen                (EXU_rd_wen),
        .EXU_result                (EXU_result),
        .EXU_is_load               (EXU_is_load),
        .EXU_csr_waddr             (EXU_csr_waddr),
        .EXU_csr_wen               (EXU_csr_wen),
        .EXU_csr_wdata             (EXU_csr_wdata),
        .MEM_fire                  (MEM_fire),
        .WB_fire                   (WB_fire),
        .MEM_load_data             (MEM_load_data),
        .MEM_load_valid            (MEM_load_valid),
        .EXU_rs1                   (EXU_rs1),
        .EXU_rs2                   (EXU_rs2),
        .EXU_csr_rs_addr           (EXU_csr_rs_addr),
        .FORWARD_rs1_data_EXU      (rs1_data),
        .FORWARD_rs2_data_EXU      (rs2_data),
        .FORWARD_csr_rs_data_EXU   (csr_data),
        .FORWARD_rs1_hazard_EXU    (rs1_hz),
        .FORWARD_rs2_hazard_EXU    (rs2_hz),
        .FORWARD_csr_rs_hazard_EXU (csr_hz),
        .FORWARD_stall_EXU         (stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then drop single-cycle strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        EXU_fire = 1'b0;
        MEM_fire = 1'b0;
        WB_fire  = 1'b0;
    endtask

    task automatic exu_gpr(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                           input logic ld);
        EXU_fire      = 1'b1;
        EXU_rd        = rd;
        EXU_rd_wen    = wen;
        EXU_result    = res;
        EXU_is_load   = ld;
        EXU_csr_wen   = 1'b0;
        EXU_csr_waddr = '0;
        EXU_csr_wdata = '0;
    endtask

    initial begin
        rst = 1'b1;
        EXU_fire = 0; EXU_rd = 0; EXU_rd_wen = 0; EXU_result = 0; EXU_is_load = 0;
        EXU_csr_waddr = 0; EXU_csr_wen = 0; EXU_csr_wdata = 0;
        MEM_fire = 0; WB_fire = 0; MEM_load_data = 0; MEM_load_valid = 0;
        EXU_rs1 = 5; EXU_rs2 = 3; EXU_csr_rs_addr = 12'h300;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_rs1_hz", 32'(rs1_hz), 32'd0);
        chk("rst_rs2_hz", 32'(rs2_hz), 32'd0);
        chk("rst_csr_hz", 32'(csr_hz), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rs1_data", rs1_data, 32'h0);
        chk("rst_csr_data", csr_data, 32'h0);

        // Simple EX->EX bypass from M.
        exu_gpr(5'd5, 1'b1, 32'h1234, 1'b0);
        tick();
        EXU_rs1 = 5; EXU_rs2 = 6;
        #1;
        chk("m_rs1_hz", 32'(rs1_hz), 32'd1);
        chk("m_rs1_data", rs1_data, 32'h1234);
        chk("m_stall", 32'(stall), 32'd0);
        chk("nomatch_rs2_hz", 32'(rs2_hz), 32'd0);
        chk("nomatch_rs2_data", rs2_data, 32'h0);

        // M and W both write x3; M is younger and wins.
        exu_gpr(5'd3, 1'b1, 32'hB, 1'b0);
        MEM_fire = 1'b1;
        tick();
        exu_gpr(5'd3, 1'b1, 32'hA, 1'b0);
        MEM_fire = 1'b1;
        tick();
        EXU_rs1 = 5; EXU_rs2 = 3;
        #1;
        chk("prio_rs2_data", rs2_data, 32'hA);
        chk("prio_rs2_hz", 32'(rs2_hz), 32'd1);
        chk("shifted_out_rs1_hz", 32'(rs1_hz), 32'd0);
        MEM_fire = 1'b1;
        tick();
        #1;
        chk("w_rs2_data", rs2_data, 32'hA);
        chk("w_rs2_hz", 32'(rs2_hz), 32'd1);
        WB_fire = 1'b1;
        tick();
        #1;
        chk("wb_retire_rs2_hz", 32'(rs2_hz), 32'd0);

        // Load-use: stall until data returns, then bypass it.
        exu_gpr(5'd7, 1'b1, 32'h5555, 1'b1);
        tick();
        EXU_rs1 = 7; EXU_rs2 = 8;
        MEM_load_valid = 1'b0;
        #1;
        chk("ld_wait_stall", 32'(stall), 32'd1);
        chk("ld_wait_rs1_hz", 32'(rs1_hz), 32'd0);
        MEM_load_valid = 1'b1;
        MEM_load_data  = 32'hDEAD;
        #1;
        chk("ld_ret_stall", 32'(stall), 32'd0);
        chk("ld_ret_rs1_hz", 32'(rs1_hz), 32'd1);
        chk("ld_ret_rs1_data", rs1_data, 32'hDEAD);
        MEM_fire = 1'b1;
        tick();
        MEM_load_valid = 1'b0;
        MEM_load_data  = 32'h0;
        #1;
        chk("ld_w_rs1_data", rs1_data, 32'hDEAD);
        chk("ld_w_stall", 32'(stall), 32'd0);

        // x0 never forwards.
        exu_gpr(5'd0, 1'b1, 32'hFFFF, 1'b0);
        tick();
        EXU_rs1 = 0; EXU_rs2 = 0;
        #1;
        chk("x0_rs1_hz", 32'(rs1_hz), 32'd0);
        chk("x0_rs1_data", rs1_data, 32'h0);
        chk("x0_rs2_hz", 32'(rs2_hz), 32'd0);

        // CSR bypass from M, then W, then retire.
        exu_gpr(5'd0, 1'b0, 32'h0, 1'b0);
        EXU_csr_wen = 1'b1; EXU_csr_waddr = 12'h300; EXU_csr_wdata = 32'h88;
        tick();
        EXU_csr_wen = 1'b0;
        EXU_csr_rs_addr = 12'h300;
        #1;
        chk("csr_m_hz", 32'(csr_hz), 32'd1);
        chk("csr_m_data", csr_data, 32'h88);
        MEM_fire = 1'b1;
        tick();
        #1;
        chk("csr_w_hz", 32'(csr_hz), 32'd1);
        chk("csr_w_data", csr_data, 32'h88);
        EXU_csr_rs_addr = 12'h301;
        #1;
        chk("csr_other_hz", 32'(csr_hz), 32'd0);
        EXU_csr_rs_addr = 12'h300;
        WB_fire = 1'b1;
        tick();
        #1;
        chk("csr_retired_hz", 32'(csr_hz), 32'd0);
        chk("csr_retired_data", csr_data, 32'h0);

        // Reset beats a concurrent fire and flushes both entries.
        exu_gpr(5'd9, 1'b1, 32'h99, 1'b0);
        tick();
        exu_gpr(5'd10, 1'b1, 32'hAA, 1'b0);
        MEM_fire = 1'b1;
        tick();
        EXU_rs1 = 9; EXU_rs2 = 10;
        #1;
        chk("pre_rst_rs1_data", rs1_data, 32'h99);
        chk("pre_rst_rs2_data", rs2_data, 32'hAA);
        rst = 1'b1;
        exu_gpr(5'd10, 1'b1, 32'hBB, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_rs1_hz", 32'(rs1_hz), 32'd0);
        chk("post_rst_rs2_hz", 32'(rs2_hz), 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);
        chk("post_rst_rs2_data", rs2_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
